mat_key_scanner: RTL
====================

MAT_KEY_SCANNER -- requirements
Module: mat_key_scanner

Interface
REQ-001 Parameter ROWS, default 4: number of sense lines (BTNY).
REQ-002 Parameter COLS, default 4: number of drive lines (BTNX).
REQ-003 Parameter SCAN_DIV, default 50000: settle cycles per column; SHALL be at least 2.
REQ-004 Parameter DB_SCANS, default 4: consecutive differing samples needed to toggle a key; SHALL be at least 1.
REQ-005 Parameter FIFO_DEPTH, default 8: event queue depth; SHALL be a power of 2.
REQ-006 Derived CODE_W = clog2(ROWS*COLS); key code = row*COLS + col.
REQ-007 sys_clk  in  1  single clock; all logic is rising-edge.
REQ-008 sys_rst  in  1  synchronous, active-high reset.
REQ-009 BTNY  in  ROWS  row sense lines; active-low, so 0 means pressed.
REQ-010 BTNX  out  COLS  column drive, registered; exactly one bit is 0 at a time.
REQ-011 btn  out  ROWS*COLS  debounced key levels; bit index is the key code.
REQ-012 evt_valid  out  1  event queue non-empty.
REQ-013 evt_code  out  CODE_W  key code of the head event.
REQ-014 evt_press  out  1  head event type: 1 is a press, 0 is a release.
REQ-015 evt_ready  in  1  consumer accepts the head event.
REQ-016 overflow  out  1  sticky flag: an event was dropped.
REQ-017 ovf_clr  in  1  clears overflow.

Function
REQ-018 BTNY SHALL pass through a 2-FF synchronizer before use.
REQ-019 FSM states:
  - SETTLE: a divider counts 0..SCAN_DIV-1. On the last SETTLE cycle, the synchronized rows are latched into samp[ROWS-1:0] as ~BTNY_sync; the FSM then enters PROC with row_idx=0.
  - PROC: one row per cycle, row_idx 0..ROWS-1. After row ROWS-1: col_idx advances (COLS-1 wraps to 0), the divider clears, and the FSM returns to SETTLE.
REQ-020 BTNX SHALL be ~(1<<col_idx) and SHALL update on the cycle SETTLE is entered. BTNX SHALL hold steady throughout SETTLE and PROC.
REQ-021 One column period SHALL be SCAN_DIV+ROWS cycles; one full scan SHALL be COLS*(SCAN_DIV+ROWS) cycles.
REQ-022 Debounce, for key k processed in PROC with sample s:
  - If s equals btn[k], cnt[k] SHALL clear to 0.
  - Otherwise cnt[k] SHALL increment.
  - When the incremented value reaches DB_SCANS, btn[k] SHALL toggle, cnt[k] SHALL clear, and one event {press=s, code=k} SHALL be pushed.
REQ-023 At most one push per cycle. Simultaneous toggles in one column SHALL therefore be queued lowest row first, on consecutive cycles.
REQ-024 The FIFO SHALL be first-word-fall-through. evt_code and evt_press SHALL be valid whenever evt_valid=1. A pop occurs when evt_valid && evt_ready.
REQ-025 FIFO boundary behaviour:
  - Push when full with no pop: the event SHALL be dropped and overflow SHALL be set; the btn toggle still occurs.
  - Full with simultaneous push and pop: both SHALL succeed, and overflow SHALL be unchanged.
  - Empty with evt_ready=1: no effect.
REQ-026 The FIFO pointers SHALL be clog2(FIFO_DEPTH)+1 bits wide and wrap naturally. The FIFO SHALL be full when the MSBs differ and the remaining bits are equal.
REQ-027 ovf_clr=1 SHALL clear overflow. If a drop happens in the same cycle, set SHALL win.
REQ-028 evt_ready SHALL have no effect on scanning. The scan SHALL never stall.

Reset
REQ-029 Synchronous reset SHALL apply the following values on the next edge:
  - FSM state SETTLE, divider 0, col_idx 0, row_idx 0.
  - BTNX = all ones except bit0=0.
  - btn=0, all cnt=0, samp=0, synchronizer flops=0.
  - FIFO empty, evt_valid=0, overflow=0.
REQ-030 Reset asserted mid-PROC or mid-SETTLE SHALL discard the in-progress sample and any pending events. Scanning SHALL restart at column 0.

Verification
Bench parameters for all scenarios: ROWS=COLS=4, SCAN_DIV=8, DB_SCANS=3, FIFO_DEPTH=4.
REQ-031 Reset, BTNY=4'hF -> BTNX=4'b1110, btn=0, evt_valid=0, overflow=0; BTNX rotates 1110, 1101, 1011, 0111 every 12 cycles.
REQ-032 Hold key (row1,col2), i.e. BTNY[1]=0 while BTNX[2]=0, for 3 scans -> btn[6]=1 after the 3rd PROC of column 2; one event {press=1, code=6}. Release for 3 scans -> btn[6]=0; event {press=0, code=6}.
REQ-033 Bounce: key 6 pressed 2 scans, released 1, pressed 2 -> btn[6] stays 0, no event.
REQ-034 Keys 2 and 14 (rows 0 and 3, col 2) pressed together for 3 scans -> events code 2 then code 14 on consecutive cycles.
REQ-035 Overflow: evt_ready=0, 5 toggles -> 4 events queued in order, 5th dropped, overflow=1. Drain with evt_ready=1 -> 4 pops in order, then evt_valid=0. ovf_clr -> overflow=0.
REQ-036 Assert sys_rst during PROC of column 3 with key 15 held -> state per REQ-029 on the next edge; no event for key 15 until 3 fresh scans complete.

Source files
------------

// File: rtl/mat_key_scanner.sv
// Column-multiplexed key matrix scanner with per-key debounce and a
// first-word-fall-through press/release event queue.
module mat_key_scanner #(
   parameter  int ROWS       = 4,
   parameter  int COLS       = 4,
   parameter  int SCAN_DIV   = 50000,
   parameter  int DB_SCANS   = 4,
   parameter  int FIFO_DEPTH = 8,
   localparam int CODE_W     = $clog2(ROWS * COLS)
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic [ROWS-1:0]        BTNY,
   output logic [COLS-1:0]        BTNX,
   output logic [ROWS*COLS-1:0]   btn,
   output logic                   evt_valid,
   output logic [CODE_W-1:0]      evt_code,
   output logic                   evt_press,
   input  logic                   evt_ready,
   output logic                   overflow,
   input  logic                   ovf_clr
);

   localparam int KEYS  = ROWS * COLS;
   localparam int DIV_W = $clog2(SCAN_DIV);
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int CNT_W = $clog2(DB_SCANS + 1);
   localparam int AW    = $clog2(FIFO_DEPTH);

   typedef enum logic {
      ST_SETTLE = 1'b0,
      ST_PROC   = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [COLS-1:0]   btnx_q, btnx_d;
   logic [ROWS-1:0]   sync1_q, sync2_q;
   logic [ROWS-1:0]   samp_q, samp_d;
   logic [KEYS-1:0]   btn_q, btn_d;
   logic [CNT_W-1:0]  cnt_q [KEYS];
   logic [CNT_W-1:0]  cnt_d [KEYS];
   logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic              ovf_q, ovf_d;
   logic [CODE_W:0]   mem_q [FIFO_DEPTH];

   logic              settle_end_s, proc_s, proc_last_s;
   logic [CODE_W-1:0] key_s;
   logic              samp_bit_s;
   logic [CNT_W-1:0]  cnt_inc_s;
   logic              push_s;
   logic [CODE_W:0]   push_data_s;
   logic              empty_s, full_s, pop_s, wr_en_s, drop_s;
   logic [CODE_W:0]   head_s;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q <= ST_SETTLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_SETTLE: state_d = settle_end_s ? ST_PROC : ST_SETTLE;
         ST_PROC:   state_d = proc_last_s ? ST_SETTLE : ST_PROC;
         default:   state_d = ST_SETTLE;
      endcase
   end

   always_comb begin
      settle_end_s = 1'b0;
      proc_s       = 1'b0;
      proc_last_s  = 1'b0;
      case (state_q)
         ST_SETTLE: settle_end_s = (div_q == DIV_W'(SCAN_DIV - 1));
         ST_PROC: begin
            proc_s      = 1'b1;
            proc_last_s = (row_q == ROW_W'(ROWS - 1));
         end
         default: begin
            settle_end_s = 1'b0;
            proc_s       = 1'b0;
            proc_last_s  = 1'b0;
         end
      endcase
   end

   // Scan counters; the column drive changes only as SETTLE is re-entered.
   always_comb begin
      div_d  = div_q;
      row_d  = '0;
      col_d  = col_q;
      btnx_d = btnx_q;
      samp_d = samp_q;
      if (state_q == ST_SETTLE && !settle_end_s) begin
         div_d = div_q + DIV_W'(1);
      end else if (proc_last_s) begin
         div_d = '0;
      end else begin
         div_d = div_q;
      end
      if (proc_s && !proc_last_s) begin
         row_d = row_q + ROW_W'(1);
      end else begin
         row_d = '0;
      end
      if (proc_last_s) begin
         col_d  = (col_q == COL_W'(COLS - 1)) ? '0 : col_q + COL_W'(1);
         btnx_d = ~(COLS'(1) << col_d);
      end else begin
         col_d  = col_q;
         btnx_d = btnx_q;
      end
      if (settle_end_s) begin
         samp_d = ~sync2_q;
      end else begin
         samp_d = samp_q;
      end
   end

   always_comb begin
      key_s       = CODE_W'(int'(row_q) * COLS + int'(col_q));
      samp_bit_s  = samp_q[row_q];
      cnt_inc_s   = cnt_q[key_s] + CNT_W'(1);
      push_data_s = {samp_bit_s, key_s};
      btn_d       = btn_q;
      cnt_d       = cnt_q;
      push_s      = 1'b0;
      if (proc_s) begin
         if (samp_bit_s == btn_q[key_s]) begin
            cnt_d[key_s] = '0;
         end else if (cnt_inc_s == CNT_W'(DB_SCANS)) begin
            btn_d[key_s] = samp_bit_s;
            cnt_d[key_s] = '0;
            push_s       = 1'b1;
         end else begin
            cnt_d[key_s] = cnt_inc_s;
         end
      end else begin
         push_s = 1'b0;
      end
   end

   // A full queue still accepts a push when the head leaves in the same cycle.
   always_comb begin
      empty_s  = (wr_ptr_q == rd_ptr_q);
      full_s   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop_s    = !empty_s && evt_ready;
      wr_en_s  = push_s && (!full_s || pop_s);
      drop_s   = push_s && full_s && !pop_s;
      wr_ptr_d = wr_en_s ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d = pop_s ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
      if (drop_s) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         div_q    <= '0;
         row_q    <= '0;
         col_q    <= '0;
         btnx_q   <= ~(COLS'(1));
         sync1_q  <= '0;
         sync2_q  <= '0;
         samp_q   <= '0;
         btn_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
         for (int i = 0; i < KEYS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         div_q    <= div_d;
         row_q    <= row_d;
         col_q    <= col_d;
         btnx_q   <= btnx_d;
         sync1_q  <= BTNY;
         sync2_q  <= sync1_q;
         samp_q   <= samp_d;
         btn_q    <= btn_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         for (int i = 0; i < KEYS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Storage needs no reset: the pointers alone define which entries are live.
   always_ff @(posedge sys_clk) begin
      if (wr_en_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data_s;
      end
   end

   assign head_s    = mem_q[rd_ptr_q[AW-1:0]];
   assign BTNX      = btnx_q;
   assign btn       = btn_q;
   assign evt_valid = !empty_s;
   assign evt_code  = head_s[CODE_W-1:0];
   assign evt_press = head_s[CODE_W];
   assign overflow  = ovf_q;

endmodule
